// File: rtl/hs_tx4p.sv
// Four-phase req/ack handshake transmitter: holds a captured word on data_out
// while driving req, waits for the synchronised acknowledge, then returns to zero.
module hs_tx4p #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             send,
  input  logic [WIDTH-1:0] data_in,
  output logic             ready,
  output logic             req,
  output logic [WIDTH-1:0] data_out,
  input  logic             ack_async,
  output logic             done,
  output logic             err
);

  // A zero TIMEOUT still needs a one-bit counter so the port-free logic stays legal.
  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
  localparam logic TO_EN = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_REL  = 2'd2
  } state_t;

  state_t                 state_r, state_nxt_s;
  logic [SYNC_STAGES-1:0] sync_r;
  logic                   ack_s;
  logic [CNT_W-1:0]       cnt_r, cnt_nxt_s;
  logic                   abort_r, abort_nxt_s;
  logic                   req_nxt_s, done_nxt_s, err_nxt_s;
  logic [WIDTH-1:0]       data_nxt_s;

  assign ack_s = sync_r[SYNC_STAGES-1];
  assign ready = (state_r == ST_IDLE);

  // Acknowledge synchroniser chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], ack_async};
    end
  end

  // Next-state and next-output decode for the handshake FSM.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    abort_nxt_s = abort_r;
    req_nxt_s   = req;
    data_nxt_s  = data_out;
    done_nxt_s  = 1'b0;
    err_nxt_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (send) begin
          data_nxt_s  = data_in;
          req_nxt_s   = 1'b1;
          cnt_nxt_s   = '0;
          abort_nxt_s = 1'b0;
          state_nxt_s = ST_REQ;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (ack_s) begin
          req_nxt_s   = 1'b0;
          state_nxt_s = ST_REL;
        end else if (TO_EN && (cnt_r == CNT_LAST)) begin
          req_nxt_s   = 1'b0;
          err_nxt_s   = 1'b1;
          abort_nxt_s = 1'b1;
          state_nxt_s = ST_REL;
        end else if (cnt_r != CNT_MAX) begin
          cnt_nxt_s = cnt_r + CNT_W'(1'b1);
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
      ST_REL: begin
        // An aborted transfer still returns through REL but reports no completion.
        if (!ack_s) begin
          done_nxt_s  = ~abort_r;
          abort_nxt_s = 1'b0;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_REL;
        end
      end
      default: begin
        req_nxt_s   = 1'b0;
        abort_nxt_s = 1'b0;
        cnt_nxt_s   = '0;
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FSM state and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      cnt_r    <= '0;
      abort_r  <= 1'b0;
      req      <= 1'b0;
      data_out <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      cnt_r    <= cnt_nxt_s;
      abort_r  <= abort_nxt_s;
      req      <= req_nxt_s;
      data_out <= data_nxt_s;
      done     <= done_nxt_s;
      err      <= err_nxt_s;
    end
  end

endmodule
